hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RV32I core. Sits beside the ID stage and drives the write-enables and flushes of the PC, IF/ID and ID/EX registers, plus a bubble into EX/MEM. Handles three cases:
- **Load-use stalls**, detected from ID source addresses against the EX destination.
- **Branch/jump redirect flushes**, with a configurable bubble depth.
- **Multi-cycle EX operations** (divider), held with a watchdog timeout.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_detect.sv | 29 ++
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: RV32I opcodes and FSM state encodings.
package hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] HZ_STATE_RUN     = 2'd0;
  localparam logic [1:0] HZ_STATE_MC_WAIT = 2'd1;
  localparam logic [1:0] HZ_STATE_FLUSH   = 2'd2;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use detector: decodes which ID sources are read and compares them to the EX load destination.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [6:0] id_opcode_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs1_used;
  logic rs2_used;

  always_comb begin
    rs1_used = !((id_opcode_i == OPC_LUI) || (id_opcode_i == OPC_AUIPC) ||
                 (id_opcode_i == OPC_JAL));
    rs2_used = (id_opcode_i == OPC_OP) || (id_opcode_i == OPC_STORE) ||
               (id_opcode_i == OPC_BRANCH);
    // A non-zero rd also excludes x0 sources from matching.
    load_use_o = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                 ((rs1_used && (id_rs1_addr_i == ex_rd_addr_i)) ||
                  (rs2_used && (id_rs2_addr_i == ex_rd_addr_i)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and multi-cycle EX holds.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [6:0]  id_opcode_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_branch_taken_i,
  input  logic        ex_mc_start_i,
  input  logic        mc_done_i,
  output logic        pc_we_o,
  output logic        if_id_we_o,
  output logic        id_ex_we_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_bubble_o,
  output logic        mc_timeout_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMER_LAST   = 8'(MC_TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] flush_left_q, flush_left_d;
  logic [7:0] timer_q, timer_d;
  logic       load_use;

  hazard_detect u_detect (
    .id_valid_i    (id_valid_i),
    .id_opcode_i   (id_opcode_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .ex_valid_i    (ex_valid_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_mem_read_i (ex_mem_read_i),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d         = state_q;
    flush_left_d    = flush_left_q;
    timer_d         = timer_q;
    pc_we_o         = 1'b1;
    if_id_we_o      = 1'b1;
    id_ex_we_o      = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_bubble_o = 1'b0;
    mc_timeout_o    = 1'b0;

    case (state_q)
      HZ_STATE_RUN: begin
        if (ex_branch_taken_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d      = HZ_STATE_FLUSH;
            flush_left_d = FLUSH_RELOAD;
          end
        end else if (ex_mc_start_i) begin
          // A start with done in the same cycle completes with no stall.
          if (!mc_done_i) begin
            pc_we_o         = 1'b0;
            if_id_we_o      = 1'b0;
            id_ex_we_o      = 1'b0;
            ex_mem_bubble_o = 1'b1;
            state_d         = HZ_STATE_MC_WAIT;
            timer_d         = '0;
          end
        end else if (load_use) begin
          pc_we_o       = 1'b0;
          if_id_we_o    = 1'b0;
          id_ex_flush_o = 1'b1;
        end
      end
      HZ_STATE_MC_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (mc_done_i) begin
          state_d = HZ_STATE_RUN;
        end else if (timer_q == TIMER_LAST) begin
          mc_timeout_o = 1'b1;
          state_d      = HZ_STATE_RUN;
        end else begin
          pc_we_o         = 1'b0;
          if_id_we_o      = 1'b0;
          id_ex_we_o      = 1'b0;
          ex_mem_bubble_o = 1'b1;
        end
      end
      HZ_STATE_FLUSH: begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
        if (ex_branch_taken_i) begin
          flush_left_d = FLUSH_RELOAD;
        end else if (flush_left_q == 3'd1) begin
          state_d = HZ_STATE_RUN;
        end else begin
          flush_left_d = flush_left_q - 3'd1;
        end
      end
      default: state_d = HZ_STATE_RUN;
    endcase

    if (rst) begin
      state_d         = HZ_STATE_RUN;
      flush_left_d    = '0;
      timer_d         = '0;
      pc_we_o         = 1'b0;
      if_id_we_o      = 1'b0;
      id_ex_we_o      = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      ex_mem_bubble_o = 1'b0;
      mc_timeout_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    flush_left_q <= flush_left_d;
    timer_q      <= timer_d;
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, !pc_we_o};
    flush_cnt_d = flush_cnt_q + {31'd0, if_id_flush_o};
    if (rst) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with FLUSH_CYCLES=2 and MC_TIMEOUT=8.
module tb_hazard_ctrl;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_MC    = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_bubble, mc_timeout}
  localparam logic [6:0] O_DEF = 7'b1110000;
  localparam logic [6:0] O_RST = 7'b0001100;
  localparam logic [6:0] O_LU  = 7'b0010100;
  localparam logic [6:0] O_FL  = 7'b1111100;
  localparam logic [6:0] O_MC  = 7'b0000010;
  localparam logic [6:0] O_TO  = 7'b1110001;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [6:0]  id_opcode_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        ex_valid_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_mem_read_i;
  logic        ex_branch_taken_i;
  logic        ex_mc_start_i;
  logic        mc_done_i;
  logic        pc_we_o;
  logic        if_id_we_o;
  logic        id_ex_we_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        ex_mem_bubble_o;
  logic        mc_timeout_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned model_stall = 0;
  int unsigned model_flush = 0;
  logic [8:0]  sb[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid_i        (id_valid_i),
    .id_opcode_i       (id_opcode_i),
    .id_rs1_addr_i     (id_rs1_addr_i),
    .id_rs2_addr_i     (id_rs2_addr_i),
    .ex_valid_i        (ex_valid_i),
    .ex_rd_addr_i      (ex_rd_addr_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_mc_start_i     (ex_mc_start_i),
    .mc_done_i         (mc_done_i),
    .pc_we_o           (pc_we_o),
    .if_id_we_o        (if_id_we_o),
    .id_ex_we_o        (id_ex_we_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_flush_o     (id_ex_flush_o),
    .ex_mem_bubble_o   (ex_mem_bubble_o),
    .mc_timeout_o      (mc_timeout_o),
    .state_o           (state_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  task automatic idle();
    id_valid_i        = 1'b0;
    id_opcode_i       = OP_IMM;
    id_rs1_addr_i     = 5'd0;
    id_rs2_addr_i     = 5'd0;
    ex_valid_i        = 1'b0;
    ex_rd_addr_i      = 5'd0;
    ex_mem_read_i     = 1'b0;
    ex_branch_taken_i = 1'b0;
    ex_mc_start_i     = 1'b0;
    mc_done_i         = 1'b0;
  endtask

  task automatic set_lu(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd);
    id_valid_i    = 1'b1;
    id_opcode_i   = opc;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
    ex_valid_i    = 1'b1;
    ex_rd_addr_i  = rd;
    ex_mem_read_i = 1'b1;
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef HAZARD_PERF_EN
    return 32'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Push the expectation for this cycle, compare mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [1:0] st, input logic [6:0] o);
    logic [8:0] e;
    logic [8:0] obs;
    logic [31:0] es;
    logic [31:0] ef;
    sb.push_back({st, o});
    @(negedge clk);
    e   = sb.pop_front();
    obs = {state_o, pc_we_o, if_id_we_o, id_ex_we_o, if_id_flush_o, id_ex_flush_o,
           ex_mem_bubble_o, mc_timeout_o};
    es  = exp_cnt(model_stall);
    ef  = exp_cnt(model_flush);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s outputs observed %b expected %b", tag, obs, e);
    end
    checks++;
    assert (stall_cnt_o === es) else begin
      errors++;
      $error("FAIL %s stall_cnt observed %0d expected %0d", tag, stall_cnt_o, es);
    end
    checks++;
    assert (flush_cnt_o === ef) else begin
      errors++;
      $error("FAIL %s flush_cnt observed %0d expected %0d", tag, flush_cnt_o, ef);
    end
    if (rst) begin
      model_stall = 0;
      model_flush = 0;
    end else begin
      if (!e[6]) model_stall++;
      if (e[3])  model_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    idle();
    step("reset0", S_RUN, O_RST);
    step("reset1", S_RUN, O_RST);
    rst = 1'b0;
    step("idle", S_RUN, O_DEF);

    set_lu(OP_REG, 5'd5, 5'd1, 5'd5);
    step("lu_rs1", S_RUN, O_LU);
    ex_mem_read_i = 1'b0;
    step("lu_clear", S_RUN, O_DEF);
    set_lu(OP_REG, 5'd1, 5'd5, 5'd5);
    step("lu_rs2", S_RUN, O_LU);
    set_lu(OP_REG, 5'd0, 5'd1, 5'd0);
    step("lu_rd_x0", S_RUN, O_DEF);
    set_lu(OP_LUI, 5'd5, 5'd5, 5'd5);
    step("lu_lui", S_RUN, O_DEF);
    set_lu(OP_IMM, 5'd1, 5'd5, 5'd5);
    step("lu_imm_rs2", S_RUN, O_DEF);
    set_lu(OP_ST, 5'd2, 5'd5, 5'd5);
    step("lu_store", S_RUN, O_LU);
    id_valid_i = 1'b0;
    step("lu_id_invalid", S_RUN, O_DEF);
    idle();

    ex_branch_taken_i = 1'b1;
    step("br_resolve", S_RUN, O_FL);
    ex_branch_taken_i = 1'b0;
    step("br_flush2", S_FLUSH, O_FL);
    step("br_done", S_RUN, O_DEF);

    set_lu(OP_REG, 5'd5, 5'd1, 5'd5);
    ex_branch_taken_i = 1'b1;
    step("br_vs_lu", S_RUN, O_FL);
    idle();
    step("br_vs_lu_flush2", S_FLUSH, O_FL);
    step("br_vs_lu_done", S_RUN, O_DEF);

    ex_branch_taken_i = 1'b1;
    step("br_reload0", S_RUN, O_FL);
    step("br_reload1", S_FLUSH, O_FL);
    ex_branch_taken_i = 1'b0;
    step("br_reload2", S_FLUSH, O_FL);
    step("br_reload_done", S_RUN, O_DEF);

    ex_mc_start_i = 1'b1;
    step("mc_start", S_RUN, O_MC);
    ex_mc_start_i = 1'b0;
    step("mc_wait1", S_MC, O_MC);
    ex_branch_taken_i = 1'b1;
    step("mc_wait2_br", S_MC, O_MC);
    ex_branch_taken_i = 1'b0;
    step("mc_wait3", S_MC, O_MC);
    step("mc_wait4", S_MC, O_MC);
    mc_done_i = 1'b1;
    step("mc_done", S_MC, O_DEF);
    mc_done_i = 1'b0;
    step("mc_after", S_RUN, O_DEF);

    ex_mc_start_i = 1'b1;
    mc_done_i     = 1'b1;
    step("mc_zero_lat", S_RUN, O_DEF);
    ex_mc_start_i = 1'b0;
    step("mc_done_stray", S_RUN, O_DEF);
    mc_done_i = 1'b0;
    step("mc_zero_after", S_RUN, O_DEF);

    ex_mc_start_i = 1'b1;
    step("wd_start", S_RUN, O_MC);
    ex_mc_start_i = 1'b0;
    for (int i = 0; i < 7; i++) step("wd_wait", S_MC, O_MC);
    step("wd_expire", S_MC, O_TO);
    step("wd_after", S_RUN, O_DEF);

    ex_mc_start_i = 1'b1;
    step("rm_start", S_RUN, O_MC);
    ex_mc_start_i = 1'b0;
    step("rm_wait1", S_MC, O_MC);
    step("rm_wait2", S_MC, O_MC);
    rst = 1'b1;
    step("rm_reset0", S_MC, O_RST);
    step("rm_reset1", S_RUN, O_RST);
    rst = 1'b0;
    step("rm_release", S_RUN, O_DEF);
    step("rm_idle", S_RUN, O_DEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
